seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the six-digit 7-segment display.
- Holds a double-buffered 6-nibble display word and one-hot, active-low selects each digit in turn.
- Presents that digit's nibble and an active-high lit enable to the shared per-digit hex decoder. The enable drives the decoder's active-low reset, so low means all segments off.
- Inserts a dark guard interval between digits against ghosting, applies per-digit and leading-zero blanking, and swaps new data in only at frame boundaries.

Parameters:
NUM_DIGITS, 6, number of digits scanned; digit 0 is least significant.
DWELL_CYC, 50000, clk cycles each digit is selected; must be >= 1.
GUARD_CYC, 8, clk cycles all digits are deselected between digits; must be >= 1.

Ports:
clk  input  1  system clock.
rst  input  1  reset, synchronous, active-low.
load_valid  input  1  new display word offered.
load_data  input  4*NUM_DIGITS  nibbles; [3:0] is digit 0.
load_blank  input  NUM_DIGITS  per-digit force-blank mask; 1 means dark.
load_lz  input  1  leading-zero blanking enable for this word.
load_ready  output  1  pending buffer empty; a load can be accepted.
dig_num  output  4  nibble of the currently selected digit.
dig_en  output  1  1 = decoder lit, 0 = decoder blank.
dig_sel  output  NUM_DIGITS  active-low one-hot digit select.
frame_start  output  1  one-cycle pulse on the first ON cycle of digit 0.

Behaviour:
- All outputs registered. All state changes on the rising clk edge.
- Reset (rst=0 at an edge), regardless of current state:
  - state=GUARD, idx=0, counter=0.
  - dig_sel all ones, dig_en=0, dig_num=0, frame_start=0.
  - load_ready=1, pending buffer cleared.
  - Active data=0, active blank mask all ones (display dark until first load), active lz=0.
- FSM has two states:
  - GUARD: dig_sel all ones, dig_en=0. Stays for GUARD_CYC cycles, then goes to ON with the current idx.
  - ON: dig_sel[idx]=0 and all other select bits 1. dig_num=active nibble[idx]; dig_en=!blanked(idx). Stays for DWELL_CYC cycles, then goes to GUARD with idx=idx+1, wrapping NUM_DIGITS-1 to 0.
- First cycle after reset release is the first GUARD cycle. Digit 0 is selected exactly GUARD_CYC cycles later.
- Frame period = NUM_DIGITS*(DWELL_CYC+GUARD_CYC) cycles.
- Frame boundary is the last GUARD cycle with idx=0:
  - If pending is full, pending data, blank mask and lz are copied to active, pending is cleared, and load_ready returns to 1 on the following cycle.
  - Active values never change mid-frame.
- Load handshake:
  - Accept when load_valid && load_ready: latch data, mask and lz into pending; load_ready=0 from the next cycle.
  - While load_ready=0, load_valid is ignored and the source must hold.
  - Acceptance and transfer cannot coincide because load_ready is 0 whenever pending is full.
- blanked(i) = active_blank[i] OR lz_blank(i).
- lz_blank(i) = active_lz AND i != 0 AND every active nibble from NUM_DIGITS-1 down to i equals 0. Digit 0 is never zero-blanked.
- A blanked digit keeps its dig_sel asserted and its dig_num driven; only dig_en=0.
- frame_start=1 only in the first ON cycle of idx=0.
- DWELL_CYC=1 and GUARD_CYC=1 must work, giving a 2-cycle digit slot.

Test Plan:
Bench uses DWELL_CYC=4, GUARD_CYC=2, NUM_DIGITS=6, giving a 36-cycle frame.
1. Reset behaviour:
   - rst=0 for 3 cycles -> dig_sel=6'b111111, dig_en=0, load_ready=1.
   - Release rst -> dig_sel=6'b111110 exactly 2 cycles later with dig_en=0 (mask all ones).
   - frame_start pulses once per 36 cycles.
2. Basic load:
   - Load 24'h123456, blank=0, lz=0 mid-frame -> load_ready=0 the next cycle; current frame unchanged.
   - Next frame shows digit0=6, 1=5, 2=4, 3=3, 4=2, 5=1, all with dig_en=1, each for 4 cycles separated by 2 dark cycles.
   - load_ready=1 on the cycle after the boundary.
3. Backpressure:
   - Offer 24'hAAAAAA then hold load_valid with 24'hBBBBBB in the same frame -> second word accepted only after the boundary.
   - Frame N+1 shows A, frame N+2 shows B.
4. Leading-zero blanking:
   - Load 24'h0000A0, lz=1 -> digits 5..2 dig_en=0; digit1 dig_num=A with dig_en=1; digit0 dig_num=0 with dig_en=1.
   - Load 24'h000000, lz=1 -> only digit0 lit.
5. Force blank: load 24'h999999, blank=6'b000100 -> during digit 2, dig_sel=6'b111011, dig_num=9, dig_en=0; all other digits lit.
6. Reset mid-operation:
   - Assert rst during ON of digit 3 with pending full -> next cycle all dark and load_ready=1.
   - After release, scan restarts at GUARD/idx 0; pending is discarded and active is dark.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a multi-digit 7-segment display.
// It keeps a double-buffered display word, which it swaps only at frame boundaries.
// Each digit is selected in turn with an active-low one-hot select for DWELL_CYC cycles.
// A dark guard of GUARD_CYC cycles separates consecutive digits.
// The shared decoder gets the selected nibble and a lit enable; per-digit and leading-zero blanking clear that enable.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset
//   load_valid  new display word offered
//   load_data   4*NUM_DIGITS nibbles, [3:0] is digit 0
//   load_blank  per-digit force-blank mask (1 = dark)
//   load_lz     leading-zero blanking enable for this word
//   load_ready  pending buffer empty, a load can be accepted
//   dig_num     nibble of the selected digit
//   dig_en      1 = decoder lit, 0 = decoder blank
//   dig_sel     active-low one-hot digit select
//   frame_start one-cycle pulse on the first ON cycle of digit 0
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DWELL_CYC  = 50000,
  parameter int unsigned GUARD_CYC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic                    load_lz,
  output logic                    load_ready,
  output logic [3:0]              dig_num,
  output logic                    dig_en,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX = (DWELL_CYC > GUARD_CYC) ? DWELL_CYC : GUARD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_W-1:0]       pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_lz_q, pend_lz_d;
  logic [DATA_W-1:0]       act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic                    act_lz_q, act_lz_d;
  logic [3:0]              dig_num_q, dig_num_d;
  logic                    dig_en_q, dig_en_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                    frame_start_q, frame_start_d;

  logic                    boundary;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   blanked;

  // Next-state, buffer handshake and registered-output computation
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q + CNT_W'(1);
    ready_d       = ready_q;
    pend_data_d   = pend_data_q;
    pend_blank_d  = pend_blank_q;
    pend_lz_d     = pend_lz_q;
    act_data_d    = act_data_q;
    act_blank_d   = act_blank_q;
    act_lz_d      = act_lz_q;
    dig_sel_d     = '1;
    dig_en_d      = 1'b0;
    dig_num_d     = 4'd0;
    frame_start_d = 1'b0;
    zero_run      = 1'b1;
    lz_mask       = '0;

    // Last guard cycle before digit 0 is the only point where active data may change
    boundary = (state_q == ST_GUARD) && (idx_q == '0) &&
               (cnt_q == CNT_W'(GUARD_CYC - 1));

    if (state_q == ST_GUARD) begin
      if (cnt_q == CNT_W'(GUARD_CYC - 1)) begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == CNT_W'(DWELL_CYC - 1)) begin
        state_d = ST_GUARD;
        cnt_d   = '0;
        idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
    end

    // Accept and transfer are exclusive: accept needs an empty pending buffer, transfer a full one
    if (ready_q && load_valid) begin
      ready_d      = 1'b0;
      pend_data_d  = load_data;
      pend_blank_d = load_blank;
      pend_lz_d    = load_lz;
    end else if (boundary && !ready_q) begin
      ready_d     = 1'b1;
      act_data_d  = pend_data_q;
      act_blank_d = pend_blank_q;
      act_lz_d    = pend_lz_q;
    end

    // Walk from the most significant digit down; a digit is zero-blanked while all above it are zero
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run   = zero_run && (act_data_d[4*i +: 4] == 4'd0);
      lz_mask[i] = act_lz_d && zero_run && (i != 0);
    end
    blanked = act_blank_d | lz_mask;

    if (state_d == ST_ON) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (idx_d == IDX_W'(i)) begin
          dig_sel_d[i] = 1'b0;
          dig_num_d    = act_data_d[4*i +: 4];
          dig_en_d     = !blanked[i];
        end
      end
    end

    frame_start_d = (state_q == ST_GUARD) && (state_d == ST_ON) && (idx_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_GUARD;
      idx_q         <= '0;
      cnt_q         <= '0;
      ready_q       <= 1'b1;
      pend_data_q   <= '0;
      pend_blank_q  <= '0;
      pend_lz_q     <= 1'b0;
      act_data_q    <= '0;
      act_blank_q   <= '1;
      act_lz_q      <= 1'b0;
      dig_num_q     <= 4'd0;
      dig_en_q      <= 1'b0;
      dig_sel_q     <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      pend_data_q   <= pend_data_d;
      pend_blank_q  <= pend_blank_d;
      pend_lz_q     <= pend_lz_d;
      act_data_q    <= act_data_d;
      act_blank_q   <= act_blank_d;
      act_lz_q      <= act_lz_d;
      dig_num_q     <= dig_num_d;
      dig_en_q      <= dig_en_d;
      dig_sel_q     <= dig_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = ready_q;
  assign dig_num     = dig_num_q;
  assign dig_en      = dig_en_q;
  assign dig_sel     = dig_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: directed frames with hand-computed digit contents.
module tb_seg7_scan_ctrl;

  localparam int unsigned N    = 6;
  localparam int unsigned DW   = 4;
  localparam int unsigned GC   = 2;
  localparam int unsigned SLOT = DW + GC;
  localparam int unsigned FRM  = N * SLOT;

  typedef struct packed {
    logic [23:0] data;
    logic [5:0]  blank;
    logic        lz;
  } word_t;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [23:0] load_data;
  logic [5:0]  load_blank;
  logic        load_lz;
  logic        load_ready;
  logic [3:0]  dig_num;
  logic        dig_en;
  logic [5:0]  dig_sel;
  logic        frame_start;

  word_t src_q[$];
  int    n_checks;
  int    n_err;
  bit    exp_ready;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N),
    .DWELL_CYC (DW),
    .GUARD_CYC (GC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_blank (load_blank),
    .load_lz    (load_lz),
    .load_ready (load_ready),
    .dig_num    (dig_num),
    .dig_en     (dig_en),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source presents the head of its queue and holds it until accepted
  task automatic drive_src();
    if (src_q.size() > 0) begin
      load_valid = 1'b1;
      load_data  = src_q[0].data;
      load_blank = src_q[0].blank;
      load_lz    = src_q[0].lz;
    end else begin
      load_valid = 1'b0;
      load_data  = '0;
      load_blank = '0;
      load_lz    = 1'b0;
    end
  endtask

  // One clock; tracks the expected load_ready across handshakes and frame boundaries
  task automatic step(input bit boundary);
    bit hs;
    hs = load_valid && exp_ready && rst;
    @(posedge clk);
    #1;
    if (hs) begin
      src_q.delete(0);
      exp_ready = 1'b0;
    end else if (boundary) begin
      exp_ready = 1'b1;
    end
    drive_src();
  endtask

  // Called on the first ON cycle of digit 0; checks every cycle of one frame
  task automatic check_frame(input int f, input logic [23:0] d_exp, input logic [5:0] en_exp,
                             input int push_at, input int np, input word_t w0, input word_t w1);
    for (int d = 0; d < int'(N); d++) begin
      for (int c = 0; c < int'(SLOT); c++) begin
        int    k;
        string t;
        logic [5:0] sel_exp;
        logic [3:0] num_exp;
        k = d * int'(SLOT) + c;
        t = $sformatf("f%0d d%0d c%0d", f, d, c);
        if (c < int'(DW)) begin
          sel_exp = ~(6'(1) << d);
          num_exp = d_exp[4*d +: 4];
          check_eq({t, " sel"}, 32'(dig_sel), 32'(sel_exp));
          check_eq({t, " num"}, 32'(dig_num), 32'(num_exp));
          check_eq({t, " en"}, 32'(dig_en), 32'(en_exp[d]));
        end else begin
          check_eq({t, " sel"}, 32'(dig_sel), 32'h3f);
          check_eq({t, " en"}, 32'(dig_en), 32'h0);
        end
        check_eq({t, " fs"}, 32'(frame_start), 32'(k == 0));
        check_eq({t, " rdy"}, 32'(load_ready), 32'(exp_ready));
        if (k == push_at) begin
          if (np > 0) src_q.push_back(w0);
          if (np > 1) src_q.push_back(w1);
          drive_src();
        end
        step(k == int'(FRM) - 1);
      end
    end
  endtask

  initial begin
    word_t none;
    n_checks  = 0;
    n_err     = 0;
    exp_ready = 1'b1;
    none      = '0;
    rst       = 1'b0;
    drive_src();

    // Reset held for three edges
    for (int i = 0; i < 3; i++) step(1'b0);
    check_eq("rst sel", 32'(dig_sel), 32'h3f);
    check_eq("rst en", 32'(dig_en), 32'h0);
    check_eq("rst num", 32'(dig_num), 32'h0);
    check_eq("rst rdy", 32'(load_ready), 32'h1);
    check_eq("rst fs", 32'(frame_start), 32'h0);

    // Release: two guard cycles then digit 0, dark because the mask starts all ones
    rst = 1'b1;
    step(1'b0);
    check_eq("rel g1 sel", 32'(dig_sel), 32'h3f);
    check_eq("rel g1 fs", 32'(frame_start), 32'h0);
    step(1'b0);
    check_eq("rel on sel", 32'(dig_sel), 32'h3e);
    check_eq("rel on en", 32'(dig_en), 32'h0);
    check_eq("rel on fs", 32'(frame_start), 32'h1);

    check_frame(0, 24'h000000, 6'b000000, 10, 1, '{24'h123456, 6'b0, 1'b0}, none);
    check_frame(1, 24'h123456, 6'b111111, 2, 2,
                '{24'hAAAAAA, 6'b0, 1'b0}, '{24'hBBBBBB, 6'b0, 1'b0});
    check_frame(2, 24'hAAAAAA, 6'b111111, -1, 0, none, none);
    check_frame(3, 24'hBBBBBB, 6'b111111, 5, 1, '{24'h0000A0, 6'b0, 1'b1}, none);
    check_frame(4, 24'h0000A0, 6'b000011, 5, 1, '{24'h000000, 6'b0, 1'b1}, none);
    check_frame(5, 24'h000000, 6'b000001, 5, 1, '{24'h999999, 6'b000100, 1'b0}, none);
    check_frame(6, 24'h999999, 6'b111011, 2, 1, '{24'h777777, 6'b0, 1'b0}, none);

    // Frame 7 shows 777777; fill pending, then reset during digit 3
    src_q.push_back('{24'h555555, 6'b0, 1'b0});
    drive_src();
    for (int i = 0; i < 3 * int'(SLOT); i++) step(1'b0);
    check_eq("mid sel", 32'(dig_sel), 32'h37);
    check_eq("mid num", 32'(dig_num), 32'h7);
    check_eq("mid en", 32'(dig_en), 32'h1);
    check_eq("mid rdy", 32'(load_ready), 32'h0);
    rst = 1'b0;
    step(1'b0);
    exp_ready = 1'b1;
    check_eq("mrst sel", 32'(dig_sel), 32'h3f);
    check_eq("mrst en", 32'(dig_en), 32'h0);
    check_eq("mrst num", 32'(dig_num), 32'h0);
    check_eq("mrst rdy", 32'(load_ready), 32'h1);
    check_eq("mrst fs", 32'(frame_start), 32'h0);
    rst = 1'b1;
    step(1'b0);
    check_eq("mrel g1 sel", 32'(dig_sel), 32'h3f);
    step(1'b0);
    check_eq("mrel on sel", 32'(dig_sel), 32'h3e);
    check_eq("mrel on fs", 32'(frame_start), 32'h1);
    check_eq("mrel on en", 32'(dig_en), 32'h0);

    // Pending word was discarded: whole frame stays dark with zero data
    check_frame(8, 24'h000000, 6'b000000, -1, 0, none, none);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
